// File: rtl/pma_tx_serializer.sv
// Transmit PMA serializer: one-symbol holding buffer, LSB-first shifter, K28.5 comma
// preamble after enable and K28.5 filler on underrun, differential line drive.
//
// state | meaning
// OFF   | electrical idle, both legs low
// COMMA | K28.5 preamble after enable, data may be buffered
// RUN   | buffered data on the line, filler on underrun
module pma_tx_serializer #(
  parameter int                    DATA_WIDTH  = 10,
  parameter int                    COMMA_COUNT = 4,
  parameter logic [DATA_WIDTH-1:0] K_NEG       = 10'h17C,
  parameter logic [DATA_WIDTH-1:0] K_POS       = 10'h283
) (
  input  logic                  Bit_Rate_Clk,
  input  logic                  Rst,
  input  logic                  Tx_Enable,
  input  logic                  TxPolarity,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  Data_Valid,
  output logic                  Data_Ready,
  output logic                  TX_Out_P,
  output logic                  TX_Out_N,
  output logic                  Word_Start,
  output logic                  Underrun,
  output logic [1:0]            Tx_State
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [7:0] COMMA_LAST = 8'(COMMA_COUNT);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_COMMA = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic [7:0]            comma_cnt_q, comma_cnt_d;
  logic                  disp_q, disp_d;
  logic                  tx_p_q, tx_p_d;
  logic                  tx_n_q, tx_n_d;
  logic                  ready_q, ready_d;
  logic                  ws_q, ws_d;
  logic                  ur_q, ur_d;
  logic [1:0]            st_q, st_d;

  logic                  last_bit;
  logic                  boundary;
  logic                  xfer;
  logic                  line_bit;
  logic [DATA_WIDTH-1:0] load_sym;
  logic [DATA_WIDTH-1:0] filler;

  assign last_bit = (bit_cnt_q == LAST_BIT);
  assign boundary = last_bit && (state_d != S_OFF);
  assign xfer     = Data_Valid && ready_q;
  assign filler   = disp_q ? K_POS : K_NEG;

  always_ff @(posedge Bit_Rate_Clk) begin
    if (Rst) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Disable is only honoured at a symbol boundary so the current symbol always completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF: begin
        if (Tx_Enable) state_d = S_COMMA;
      end
      S_COMMA: begin
        if (last_bit) begin
          if (!Tx_Enable)                     state_d = S_OFF;
          else if (comma_cnt_q == COMMA_LAST) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_bit && !Tx_Enable) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    comma_cnt_d = comma_cnt_q;
    disp_d      = disp_q;
    load_sym    = '0;
    line_bit    = 1'b0;
    ur_d        = 1'b0;

    if (xfer) begin
      buf_d      = Data_in;
      buf_full_d = 1'b1;
    end

    if (state_d == S_OFF) begin
      bit_cnt_d = LAST_BIT;
    end else if (boundary) begin
      bit_cnt_d = '0;
      if (state_q == S_OFF) begin
        load_sym    = K_NEG;
        disp_d      = 1'b1;
        comma_cnt_d = 8'd1;
      end else if (state_d == S_COMMA) begin
        load_sym    = filler;
        disp_d      = ~disp_q;
        comma_cnt_d = comma_cnt_q + 8'd1;
      end else if (buf_full_q) begin
        load_sym   = buf_q;
        buf_full_d = 1'b0;
      end else begin
        load_sym = filler;
        disp_d   = ~disp_q;
        ur_d     = 1'b1;
      end
      line_bit = load_sym[0];
      shift_d  = load_sym >> 1;
    end else begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      line_bit  = shift_q[0];
      shift_d   = shift_q >> 1;
    end

    tx_p_d  = (state_d != S_OFF) && (line_bit ^ TxPolarity);
    tx_n_d  = (state_d != S_OFF) && !(line_bit ^ TxPolarity);
    ready_d = (state_d != S_OFF) && !buf_full_d;
    ws_d    = boundary;
    st_d    = state_d;
  end

  always_ff @(posedge Bit_Rate_Clk) begin
    if (Rst) begin
      bit_cnt_q   <= LAST_BIT;
      shift_q     <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      comma_cnt_q <= '0;
      disp_q      <= 1'b0;
      tx_p_q      <= 1'b0;
      tx_n_q      <= 1'b0;
      ready_q     <= 1'b0;
      ws_q        <= 1'b0;
      ur_q        <= 1'b0;
      st_q        <= 2'd0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      comma_cnt_q <= comma_cnt_d;
      disp_q      <= disp_d;
      tx_p_q      <= tx_p_d;
      tx_n_q      <= tx_n_d;
      ready_q     <= ready_d;
      ws_q        <= ws_d;
      ur_q        <= ur_d;
      st_q        <= st_d;
    end
  end

  assign TX_Out_P   = tx_p_q;
  assign TX_Out_N   = tx_n_q;
  assign Data_Ready = ready_q;
  assign Word_Start = ws_q;
  assign Underrun   = ur_q;
  assign Tx_State   = st_q;

endmodule

// File: tb/tb_pma_tx_serializer.sv
// Directed bench for pma_tx_serializer: outputs sampled on the falling edge, one
// symbol captured per 10 cycles starting at the cycle its bit 0 is on the line.
module tb_pma_tx_serializer;

  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Tx_Enable = 1'b0;
  logic       TxPolarity = 1'b0;
  logic [9:0] Data_in = '0;
  logic       Data_Valid = 1'b0;
  logic       Data_Ready;
  logic       TX_Out_P;
  logic       TX_Out_N;
  logic       Word_Start;
  logic       Underrun;
  logic [1:0] Tx_State;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  logic [9:0] src_q[$];

  pma_tx_serializer dut (
    .Bit_Rate_Clk(clk),
    .Rst(Rst),
    .Tx_Enable(Tx_Enable),
    .TxPolarity(TxPolarity),
    .Data_in(Data_in),
    .Data_Valid(Data_Valid),
    .Data_Ready(Data_Ready),
    .TX_Out_P(TX_Out_P),
    .TX_Out_N(TX_Out_N),
    .Word_Start(Word_Start),
    .Underrun(Underrun),
    .Tx_State(Tx_State)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; a source that saw Data_Ready offers its next word afterwards.
  task automatic step();
    logic xfer;
    xfer = Data_Valid && Data_Ready;
    @(negedge clk);
    if (xfer) begin
      acc_cnt++;
      if (src_q.size() > 0) Data_in = src_q.pop_front();
      else Data_Valid = 1'b0;
    end
  endtask

  task automatic start_src();
    if (!Data_Valid && src_q.size() > 0) begin
      Data_in    = src_q.pop_front();
      Data_Valid = 1'b1;
    end
  endtask

  task automatic grab(output logic [9:0] p, output logic [9:0] n, output logic [9:0] ws,
                      output logic [9:0] ur, output logic [9:0] rdy, output logic [1:0] st);
    st = Tx_State;
    for (int k = 0; k < 10; k++) begin
      p[k] = TX_Out_P; n[k] = TX_Out_N; ws[k] = Word_Start; ur[k] = Underrun; rdy[k] = Data_Ready;
      step();
    end
  endtask

  // Capture a symbol while dropping Tx_Enable in the cycle bit drop_k is on the line.
  task automatic grab_drop(input int drop_k, output logic [9:0] p);
    for (int k = 0; k < 10; k++) begin
      p[k] = TX_Out_P;
      if (k == drop_k) Tx_Enable = 1'b0;
      step();
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1; Tx_Enable = 1'b0; TxPolarity = 1'b0; Data_Valid = 1'b0;
    src_q.delete();
    step(); step();
    Rst = 1'b0;
    acc_cnt = 0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Tx_Enable = 1'b1;
    step(); step();
    n_checks++; if (TX_Out_P !== 1'b0 || TX_Out_N !== 1'b0) begin n_fail++; $display("FAIL reset_line: got P=%b N=%b, want 0/0", TX_Out_P, TX_Out_N); end
    n_checks++; if (Data_Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, want 0", Data_Ready); end
    n_checks++; if (Word_Start !== 1'b0 || Underrun !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got ws=%b ur=%b, want 0/0", Word_Start, Underrun); end
    n_checks++; if (Tx_State !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, want 0", Tx_State); end
    Tx_Enable = 1'b0; Rst = 1'b0;
    step(); step(); step();
    n_checks++; if (Tx_State !== 2'd0 || TX_Out_P !== 1'b0 || TX_Out_N !== 1'b0 || Data_Ready !== 1'b0) begin
      n_fail++; $display("FAIL off_idle: got st=%0d P=%b N=%b rdy=%b, want 0 0 0 0", Tx_State, TX_Out_P, TX_Out_N, Data_Ready); end
  endtask

  task automatic test_comma();
    logic [9:0] p, n, ws, ur, rdy, exp;
    logic [1:0] st;
    do_reset();
    Tx_Enable = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 10'h17C : 10'h283;
      grab(p, n, ws, ur, rdy, st);
      n_checks++; if (p !== exp) begin n_fail++; $display("FAIL comma_p[%0d]: got %h, want %h", i, p, exp); end
      n_checks++; if (n !== ~exp) begin n_fail++; $display("FAIL comma_n[%0d]: got %h, want %h", i, n, ~exp); end
      n_checks++; if (ws !== 10'h001) begin n_fail++; $display("FAIL comma_ws[%0d]: got %h, want 001", i, ws); end
      n_checks++; if (ur !== 10'h000) begin n_fail++; $display("FAIL comma_ur[%0d]: got %h, want 000", i, ur); end
      n_checks++; if (st !== 2'd1) begin n_fail++; $display("FAIL comma_st[%0d]: got %0d, want 1", i, st); end
    end
    grab(p, n, ws, ur, rdy, st);
    n_checks++; if (p !== 10'h17C) begin n_fail++; $display("FAIL fill0_p: got %h, want 17c", p); end
    n_checks++; if (ur !== 10'h001) begin n_fail++; $display("FAIL fill0_ur: got %h, want 001", ur); end
    n_checks++; if (st !== 2'd2) begin n_fail++; $display("FAIL fill0_st: got %0d, want 2", st); end
    n_checks++; if (ws !== 10'h001) begin n_fail++; $display("FAIL fill0_ws: got %h, want 001", ws); end
    grab(p, n, ws, ur, rdy, st);
    n_checks++; if (p !== 10'h283 || ur !== 10'h001) begin n_fail++; $display("FAIL fill1: got p=%h ur=%h, want 283 001", p, ur); end
  endtask

  task automatic test_handshake();
    logic [9:0] p, n, ws, ur, rdy;
    logic [1:0] st;
    do_reset();
    src_q.push_back(10'h2AA); src_q.push_back(10'h155);
    Tx_Enable = 1'b1;
    step();
    start_src();
    grab(p, n, ws, ur, rdy, st);
    n_checks++; if (rdy !== 10'h001) begin n_fail++; $display("FAIL hs_rdy_c0: got %h, want 001", rdy); end
    for (int i = 1; i < 4; i++) begin
      grab(p, n, ws, ur, rdy, st);
      n_checks++; if (rdy !== 10'h000) begin n_fail++; $display("FAIL hs_rdy_c%0d: got %h, want 000", i, rdy); end
    end
    grab(p, n, ws, ur, rdy, st);
    n_checks++; if (p !== 10'h2AA || ur !== 10'h000) begin n_fail++; $display("FAIL hs_d0: got p=%h ur=%h, want 2aa 000", p, ur); end
    n_checks++; if (rdy !== 10'h001) begin n_fail++; $display("FAIL hs_rdy_d0: got %h, want 001", rdy); end
    grab(p, n, ws, ur, rdy, st);
    n_checks++; if (p !== 10'h155 || ur !== 10'h000) begin n_fail++; $display("FAIL hs_d1: got p=%h ur=%h, want 155 000", p, ur); end
    n_checks++; if (rdy !== 10'h3FF) begin n_fail++; $display("FAIL hs_rdy_d1: got %h, want 3ff", rdy); end
    grab(p, n, ws, ur, rdy, st);
    n_checks++; if (p !== 10'h17C || ur !== 10'h001) begin n_fail++; $display("FAIL hs_fill: got p=%h ur=%h, want 17c 001", p, ur); end
    n_checks++; if (acc_cnt !== 2) begin n_fail++; $display("FAIL hs_accepts: got %0d, want 2", acc_cnt); end
  endtask

  task automatic test_polarity();
    logic [9:0] p, n, ws, ur, rdy;
    logic [1:0] st;
    do_reset();
    TxPolarity = 1'b1;
    src_q.push_back(10'h0F0);
    Tx_Enable = 1'b1;
    step();
    start_src();
    grab(p, n, ws, ur, rdy, st);
    // Inverted K_NEG reads as 283 on P.
    n_checks++; if (p !== 10'h283 || n !== 10'h17C) begin n_fail++; $display("FAIL pol_comma: got p=%h n=%h, want 283 17c", p, n); end
    for (int i = 1; i < 4; i++) grab(p, n, ws, ur, rdy, st);
    grab(p, n, ws, ur, rdy, st);
    n_checks++; if (p !== 10'h30F) begin n_fail++; $display("FAIL pol_data_p: got %h, want 30f", p); end
    n_checks++; if (n !== 10'h0F0) begin n_fail++; $display("FAIL pol_data_n: got %h, want 0f0", n); end
    TxPolarity = 1'b0;
  endtask

  task automatic test_disable();
    logic [9:0] p, n, ws, ur, rdy;
    logic [1:0] st;
    do_reset();
    src_q.push_back(10'h3C5);
    Tx_Enable = 1'b1;
    step();
    start_src();
    for (int i = 0; i < 4; i++) grab(p, n, ws, ur, rdy, st);
    grab_drop(3, p);
    n_checks++; if (p !== 10'h3C5) begin n_fail++; $display("FAIL dis_data: got %h, want 3c5", p); end
    n_checks++; if (TX_Out_P !== 1'b0 || TX_Out_N !== 1'b0 || Tx_State !== 2'd0) begin
      n_fail++; $display("FAIL dis_off: got P=%b N=%b st=%0d, want 0 0 0", TX_Out_P, TX_Out_N, Tx_State); end
    n_checks++; if (Word_Start !== 1'b0 || Data_Ready !== 1'b0) begin n_fail++; $display("FAIL dis_flags: got ws=%b rdy=%b, want 0 0", Word_Start, Data_Ready); end
    step(); step(); step();
    n_checks++; if (TX_Out_P !== 1'b0 || TX_Out_N !== 1'b0 || Tx_State !== 2'd0) begin
      n_fail++; $display("FAIL dis_hold: got P=%b N=%b st=%0d, want 0 0 0", TX_Out_P, TX_Out_N, Tx_State); end
    Tx_Enable = 1'b1;
    step();
    n_checks++; if (Tx_State !== 2'd1) begin n_fail++; $display("FAIL reen_st: got %0d, want 1", Tx_State); end
    grab_drop(3, p);
    n_checks++; if (p !== 10'h17C) begin n_fail++; $display("FAIL reen_first: got %h, want 17c", p); end
    n_checks++; if (Tx_State !== 2'd0) begin n_fail++; $display("FAIL dis_comma_st: got %0d, want 0", Tx_State); end
    // Filler disparity was left positive; a fresh preamble still starts negative.
    Tx_Enable = 1'b1;
    step();
    grab(p, n, ws, ur, rdy, st);
    n_checks++; if (p !== 10'h17C || st !== 2'd1) begin n_fail++; $display("FAIL reen2_first: got p=%h st=%0d, want 17c 1", p, st); end
    grab(p, n, ws, ur, rdy, st);
    n_checks++; if (p !== 10'h283) begin n_fail++; $display("FAIL reen2_second: got %h, want 283", p); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] p, n, ws, ur, rdy;
    logic [1:0] st;
    do_reset();
    src_q.push_back(10'h111); src_q.push_back(10'h222);
    Tx_Enable = 1'b1;
    step();
    start_src();
    grab(p, n, ws, ur, rdy, st);
    for (int k = 0; k < 5; k++) step();
    Rst = 1'b1; Tx_Enable = 1'b0; Data_Valid = 1'b0; src_q.delete();
    step();
    n_checks++; if (TX_Out_P !== 1'b0 || TX_Out_N !== 1'b0) begin n_fail++; $display("FAIL rmid_line: got P=%b N=%b, want 0/0", TX_Out_P, TX_Out_N); end
    n_checks++; if (Data_Ready !== 1'b0 || Tx_State !== 2'd0) begin n_fail++; $display("FAIL rmid_ctrl: got rdy=%b st=%0d, want 0 0", Data_Ready, Tx_State); end
    Rst = 1'b0;
    step();
    Tx_Enable = 1'b1;
    step();
    grab(p, n, ws, ur, rdy, st);
    n_checks++; if (p !== 10'h17C) begin n_fail++; $display("FAIL rmid_first: got %h, want 17c", p); end
    n_checks++; if (rdy !== 10'h3FF) begin n_fail++; $display("FAIL rmid_empty: got rdy=%h, want 3ff", rdy); end
    for (int i = 1; i < 4; i++) grab(p, n, ws, ur, rdy, st);
    grab(p, n, ws, ur, rdy, st);
    n_checks++; if (p !== 10'h17C || ur !== 10'h001) begin n_fail++; $display("FAIL rmid_run: got p=%h ur=%h, want 17c 001", p, ur); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] p, n, ws, ur, rdy, exp;
    logic [1:0] st;
    do_reset();
    for (int i = 0; i < 12; i++) src_q.push_back(10'(10'h100 + i));
    Tx_Enable = 1'b1;
    step();
    start_src();
    for (int i = 0; i < 4; i++) grab(p, n, ws, ur, rdy, st);
    for (int i = 0; i < 12; i++) begin
      exp = 10'(10'h100 + i);
      grab(p, n, ws, ur, rdy, st);
      n_checks++; if (p !== exp || ur !== 10'h000) begin n_fail++; $display("FAIL b2b_d[%0d]: got p=%h ur=%h, want %h 000", i, p, ur, exp); end
      if (i < 11) begin
        n_checks++; if (rdy !== 10'h001) begin n_fail++; $display("FAIL b2b_rdy[%0d]: got %h, want 001", i, rdy); end
      end
    end
    grab(p, n, ws, ur, rdy, st);
    n_checks++; if (p !== 10'h17C || ur !== 10'h001) begin n_fail++; $display("FAIL b2b_fill: got p=%h ur=%h, want 17c 001", p, ur); end
    n_checks++; if (acc_cnt !== 12) begin n_fail++; $display("FAIL b2b_accepts: got %0d, want 12", acc_cnt); end
  endtask

  initial begin
    test_reset();
    test_comma();
    test_handshake();
    test_polarity();
    test_disable();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
